// File: rtl/imem_dmem_port_arbiter_pkg.sv
// rtl/imem_dmem_port_arbiter_pkg.sv - shared encodings and default widths for the unified memory port
package mips_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_e;

  // Byte-enable width for a given data word width.
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/imem_dmem_port_arbiter_if.sv
// rtl/imem_dmem_port_arbiter_if.sv - requester and memory signal bundle around the port arbiter
interface imem_dmem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  // Data requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  // Memory command/response
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Pipeline plus memory wrapper side
  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/imem_dmem_port_arbiter_arb_priority_sel.sv
// rtl/imem_dmem_port_arbiter_arb_priority_sel.sv - grant decision; fairness override under ARB_FETCH_FAIRNESS_EN
module arb_priority_sel
  import mips_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned STREAK_W        = 3
) (
  input  logic                i_dm_req,
  input  logic                i_if_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant_valid,
  output arb_owner_e          o_grant_owner
);

`ifndef ARB_FETCH_FAIRNESS_EN
  logic w_unused_streak;
  assign w_unused_streak = ^i_streak;
`endif

  // Data belongs to the older instruction so it wins; a long data streak hands one slot to fetch.
  always_comb begin
    o_grant_valid = i_dm_req | i_if_req;
    o_grant_owner = FETCH;
    if (i_dm_req) begin
      o_grant_owner = DATA;
    end
`ifdef ARB_FETCH_FAIRNESS_EN
    if (i_dm_req && i_if_req && (i_streak == STREAK_W'(MAX_DATA_STREAK))) begin
      o_grant_owner = FETCH;
    end
`endif
  end

endmodule

// File: rtl/imem_dmem_port_arbiter_dffare.sv
// rtl/imem_dmem_port_arbiter_dffare.sv - enabled register with asynchronous active-low reset
module dffare #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; reset value on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - fetch/data arbiter for one single-ported memory; optional ARB_FETCH_FAIRNESS_EN
module imem_dmem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  imem_dmem_port_arbiter_if.slave   bus
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                w_cmd_load;
  logic                w_if_rd_en;
  logic                w_dm_rd_en;

  logic                w_grant_valid;
  arb_owner_e          w_grant_owner;
  logic [0:0]          r_owner;
  logic [STREAK_W-1:0] w_streak;

  logic                w_cmd_we;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [DATA_W-1:0]   w_cmd_wdata;
  logic [BE_W-1:0]     w_cmd_be;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_be;
  logic                r_if_ack;
  logic                r_dm_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  arb_priority_sel #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_sel (
    .i_dm_req      (bus.dm_req),
    .i_if_req      (bus.if_req),
    .i_streak      (w_streak),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the load strobes for command and read-data registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_load  = 1'b0;
    w_if_rd_en  = 1'b0;
    w_dm_rd_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_cmd_load  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          w_state_nxt = r_mem_we ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          w_state_nxt = ACK;
          w_if_rd_en  = (r_owner == FETCH);
          w_dm_rd_en  = (r_owner == DATA);
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command fields of the granted requester; fetch is always a full-word read.
  always_comb begin
    w_cmd_we    = 1'b0;
    w_cmd_addr  = bus.if_addr;
    w_cmd_wdata = '0;
    w_cmd_be    = '1;
    if (w_grant_owner == DATA) begin
      w_cmd_we    = bus.dm_we;
      w_cmd_addr  = bus.dm_addr;
      w_cmd_wdata = bus.dm_wdata;
      w_cmd_be    = bus.dm_be;
    end
  end

`ifdef ARB_FETCH_FAIRNESS_EN
  logic                r_streak_q;
  logic                w_streak_en;
  logic [STREAK_W-1:0] w_streak_d;
  logic [STREAK_W-1:0] r_streak;

  assign r_streak_q  = 1'b0;
  assign w_streak_en = w_cmd_load &&
                       ((w_grant_owner == FETCH) || bus.if_req);
  assign w_streak_d  = (w_grant_owner == FETCH)                 ? '0 :
                       (r_streak == STREAK_W'(MAX_DATA_STREAK)) ? r_streak :
                                                                  r_streak + STREAK_W'(1);

  dffare #(.W(STREAK_W)) u_streak (
    .clk(clk), .rst_n(rst), .en(w_streak_en), .d(w_streak_d), .q(r_streak)
  );
  assign w_streak = r_streak;
`else
  assign w_streak = '0;
`endif

  dffare #(.W(1), .RST_VAL(FETCH)) u_owner (
    .clk(clk), .rst_n(rst), .en(w_cmd_load), .d(w_grant_owner), .q(r_owner)
  );
  dffare #(.W(1)) u_mem_req (
    .clk(clk), .rst_n(rst), .en(1'b1), .d(w_state_nxt == ISSUE), .q(r_mem_req)
  );
  dffare #(.W(1)) u_mem_we (
    .clk(clk), .rst_n(rst), .en(w_cmd_load), .d(w_cmd_we), .q(r_mem_we)
  );
  dffare #(.W(ADDR_W)) u_mem_addr (
    .clk(clk), .rst_n(rst), .en(w_cmd_load), .d(w_cmd_addr), .q(r_mem_addr)
  );
  dffare #(.W(DATA_W)) u_mem_wdata (
    .clk(clk), .rst_n(rst), .en(w_cmd_load), .d(w_cmd_wdata), .q(r_mem_wdata)
  );
  dffare #(.W(BE_W)) u_mem_be (
    .clk(clk), .rst_n(rst), .en(w_cmd_load), .d(w_cmd_be), .q(r_mem_be)
  );
  dffare #(.W(1)) u_if_ack (
    .clk(clk), .rst_n(rst), .en(1'b1),
    .d((w_state_nxt == ACK) && (r_owner == FETCH)), .q(r_if_ack)
  );
  dffare #(.W(1)) u_dm_ack (
    .clk(clk), .rst_n(rst), .en(1'b1),
    .d((w_state_nxt == ACK) && (r_owner == DATA)), .q(r_dm_ack)
  );
  dffare #(.W(DATA_W)) u_if_rdata (
    .clk(clk), .rst_n(rst), .en(w_if_rd_en), .d(bus.mem_rdata), .q(r_if_rdata)
  );
  dffare #(.W(DATA_W)) u_dm_rdata (
    .clk(clk), .rst_n(rst), .en(w_dm_rd_en), .d(bus.mem_rdata), .q(r_dm_rdata)
  );

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;

  // Stalls come only from requests and registered acks, never from memory inputs.
  assign bus.if_stall  = bus.if_req & ~r_if_ack;
  assign bus.dm_stall  = bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - directed bench for imem_dmem_port_arbiter
module tb_imem_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic       found;
    logic [7:0] exp_g;
    logic [7:0] obs_g;

    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    step(); step();
    rst = 1'b1;
    #1;
    check("rst_mem_req",  bus.mem_req,  0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be",   bus.mem_be,   0);
    check("rst_if_ack",   bus.if_ack,   0);
    check("rst_dm_ack",   bus.dm_ack,   0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);

    // Fetch only
    step();
    bus.if_req = 1; bus.if_addr = 32'h0040_0000; bus.mem_ready = 1;
    #1 check("f_stall_req", bus.if_stall, 1);
    step(); #1;
    check("f_mem_req",  bus.mem_req,  1);
    check("f_mem_addr", bus.mem_addr, 32'h0040_0000);
    check("f_mem_we",   bus.mem_we,   0);
    check("f_mem_be",   bus.mem_be,   4'hF);
    check("f_stall_iss", bus.if_stall, 1);
    step();
    check("f_req_drop", bus.mem_req, 0);
    check("f_ack_wait", bus.if_ack, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h8C08_0004;
    step();
    bus.mem_rvalid = 0;
    #1;
    check("f_ack",      bus.if_ack,   1);
    check("f_rdata",    bus.if_rdata, 32'h8C08_0004);
    check("f_stall_ack", bus.if_stall, 0);
    bus.if_req = 0;
    step(); #1;
    check("f_ack_once", bus.if_ack,   0);
    check("f_rd_hold",  bus.if_rdata, 32'h8C08_0004);
    check("f_dm_rdata", bus.dm_rdata, 0);

    // Simultaneous fetch and load: data first
    bus.if_req = 1; bus.if_addr = 32'h0040_0004;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h1001_0000;
    step(); #1;
    check("s_d_addr",   bus.mem_addr, 32'h1001_0000);
    check("s_d_we",     bus.mem_we,   0);
    check("s_if_stall1", bus.if_stall, 1);
    check("s_dm_stall1", bus.dm_stall, 1);
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1122_3344;
    #1 check("s_if_stall2", bus.if_stall, 1);
    step();
    bus.mem_rvalid = 0;
    #1;
    check("s_dm_ack",   bus.dm_ack,   1);
    check("s_dm_rdata", bus.dm_rdata, 32'h1122_3344);
    check("s_dm_stall", bus.dm_stall, 0);
    check("s_if_stall3", bus.if_stall, 1);
    check("s_if_noack", bus.if_ack,   0);
    check("s_if_hold",  bus.if_rdata, 32'h8C08_0004);
    bus.dm_req = 0;
    step(); #1;
    check("s_idle_req", bus.mem_req, 0);
    step(); #1;
    check("s_f_req",    bus.mem_req,  1);
    check("s_f_addr",   bus.mem_addr, 32'h0040_0004);
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h2402_0005;
    step();
    bus.mem_rvalid = 0;
    #1;
    check("s_if_ack",   bus.if_ack,   1);
    check("s_if_rdata", bus.if_rdata, 32'h2402_0005);
    check("s_dm_hold",  bus.dm_rdata, 32'h1122_3344);
    bus.if_req = 0;
    step(); #1;
    check("s_if_ack_off", bus.if_ack, 0);

    // Store with memory back-pressure
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'b0011;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_addr = 32'h1001_0008; bus.mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      check("w_req",   bus.mem_req,   1);
      check("w_we",    bus.mem_we,    1);
      check("w_be",    bus.mem_be,    4'b0011);
      check("w_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check("w_addr",  bus.mem_addr,  32'h1001_0008);
      check("w_noack", bus.dm_ack,    0);
    end
    bus.mem_ready = 1;
    step(); #1;
    check("w_ack",     bus.dm_ack,   1);
    check("w_req_off", bus.mem_req,  0);
    check("w_rd_hold", bus.dm_rdata, 32'h1122_3344);
    bus.dm_req = 0; bus.dm_we = 0;
    step(); #1;
    check("w_ack_once", bus.dm_ack, 0);

    // Reset during WAIT, stale rvalid afterwards
    bus.if_req = 1; bus.if_addr = 32'h0040_0008;
    step(); step();
    rst = 1'b0;
    bus.if_req = 0;
    #1;
    check("r_mem_req",  bus.mem_req,  0);
    check("r_mem_addr", bus.mem_addr, 0);
    check("r_if_rdata", bus.if_rdata, 0);
    check("r_dm_rdata", bus.dm_rdata, 0);
    step();
    rst = 1'b1;
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.mem_rvalid = 0;
    #1;
    check("r_no_if_ack", bus.if_ack,   0);
    check("r_no_dm_ack", bus.dm_ack,   0);
    check("r_rd_clear",  bus.if_rdata, 0);
    check("r_idle",      bus.mem_req,  0);
    bus.if_req = 1; bus.if_addr = 32'h0040_000C;
    step(); #1;
    check("r_new_req",  bus.mem_req,  1);
    check("r_new_addr", bus.mem_addr, 32'h0040_000C);
    step();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0001;
    step();
    bus.mem_rvalid = 0;
    #1 check("r_new_ack", bus.if_ack, 1);
    bus.if_req = 0;
    step();

    // Both requesters held continuously
    bus.if_req = 1; bus.if_addr = 32'h0040_0010;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h1001_0010;
    for (int t = 0; t < 10; t++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        step(); #1;
        if (bus.mem_req) found = 1'b1;
      end
      check("g_seen", found, 1);
      if (found) begin
`ifdef ARB_FETCH_FAIRNESS_EN
        exp_g = ((t % 5) == 4) ? "F" : "D";
`else
        exp_g = "D";
`endif
        obs_g = (bus.mem_addr == 32'h1001_0010) ? "D" : "F";
        check($sformatf("g_seq%0d", t), obs_g, exp_g);
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0100 + t;
        step();
        bus.mem_rvalid = 0;
        #1 check($sformatf("g_ack%0d", t), {bus.if_ack, bus.dm_ack},
                 (exp_g == "D") ? 2'b01 : 2'b10);
      end
    end
    bus.if_req = 0; bus.dm_req = 0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
